// File: rtl/clk_enable_bank_if.sv
// Bundled control and output signals of clk_enable_bank.
// The master drives the controls and reads the tick and level outputs.
interface clk_enable_bank_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 27,
    parameter int SEL_W  = 3
);
    logic              sync;
    logic              hold;
    logic              div_wr;
    logic [SEL_W-1:0]  div_sel;
    logic [CNT_W-1:0]  div_data;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] level;

    modport master (
        output sync, hold, div_wr, div_sel, div_data,
        input  tick, level
    );

    modport slave (
        input  sync, hold, div_wr, div_sel, div_data,
        output tick, level
    );
endinterface

// File: rtl/clk_enable_bank.sv
// Multi-channel timebase. Each channel produces a one-cycle tick enable and a 50% level.
// Optional CLKDIV_RUNTIME_EN adds writable divisors. Without it, the divisors are the DIVS constants.
module clk_enable_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 27,
    parameter logic [NUM_CH*CNT_W-1:0] DIVS = {27'd33_333_333, 27'd200_000,
                                               27'd50_000_000, 27'd100_000_000},
    parameter int SEL_W  = 3
) (
    input logic              clk,
    input logic              RESET,
    clk_enable_bank_if.slave bus
);
    logic [CNT_W-1:0]  div_eff [NUM_CH];
    logic [NUM_CH-1:0] wr_hit;

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] level_q, level_d;

`ifdef CLKDIV_RUNTIME_EN
    logic [CNT_W-1:0] div_q [NUM_CH];
    logic [CNT_W-1:0] div_d [NUM_CH];

    // A select at or above NUM_CH matches no channel, so that write is dropped.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i]  = bus.div_wr && (bus.div_sel == SEL_W'(i));
            div_d[i]   = wr_hit[i] ? bus.div_data : div_q[i];
            div_eff[i] = div_q[i];
        end
    end

    // NOTE: the divisor bank is a handful of flops, so it takes the DIVS values on reset.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DIVS[i*CNT_W +: CNT_W];
            end
        end else begin
            div_q <= div_d;
        end
    end
`else
    logic [SEL_W-1:0] unused_div_sel;
    logic             unused_div_bits;
    assign unused_div_sel  = bus.div_sel;
    assign unused_div_bits = ^{bus.div_wr, bus.div_data};

    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            div_eff[i] = DIVS[i*CNT_W +: CNT_W];
        end
    end
`endif

    // Per-channel priority: sync, then write, then hold or disabled, then count.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        tick_d  = '0;
        level_d = level_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.sync || wr_hit[i]) begin
                cnt_d[i]   = '0;
                level_d[i] = 1'b0;
            end else if (div_eff[i] == '0) begin
                cnt_d[i] = '0;
            end else if (bus.hold) begin
                cnt_d[i] = cnt_q[i];
            end else if (cnt_q[i] == div_eff[i] - CNT_W'(1)) begin
                cnt_d[i]   = '0;
                tick_d[i]  = 1'b1;
                level_d[i] = ~level_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            tick_q  <= '0;
            level_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            level_q <= level_d;
        end
    end

    assign bus.tick  = tick_q;
    assign bus.level = level_q;
endmodule

// File: doc/clk_enable_bank.md
Name: clk_enable_bank

Overview:
- Parametrised multi-channel timebase for the stopwatch/clock datapath.
- Replaces the fixed 1 Hz / 2 Hz / 500 Hz / blink divider.
- Each channel derives a one-cycle tick enable and a 50%-duty toggle level from the single system clock.
- Adds per-channel runtime divisors, a global phase-sync restart, and a hold freeze, so downstream counters, the display mux and the blink logic run on clean enables instead of derived clocks.

Parameters:
- NUM_CH, 4, number of channels (1..8).
- CNT_W, 27, width of each divisor and counter.
- DIVS, {33_333_333, 200_000, 50_000_000, 100_000_000}, packed NUM_CH*CNT_W reset divisors; channel i occupies bits [i*CNT_W +: CNT_W]. Defaults: ch0 1 Hz tick, ch1 2 Hz tick, ch2 500 Hz tick, ch3 ~3 Hz blink tick at 100 MHz.
- SEL_W, 3, width of the channel select (must satisfy 2^SEL_W >= NUM_CH).

Ports:
- clk  in  1  system clock, all logic on posedge.
- RESET  in  1  asynchronous, active-low reset.
- sync  in  1  synchronous restart of all channels; used for phase alignment.
- hold  in  1  freezes all counters; no ticks while high.
- div_wr  in  1  one-cycle divisor write strobe.
- div_sel  in  SEL_W  channel addressed by div_wr.
- div_data  in  CNT_W  new divisor value.
- tick  out  NUM_CH  per-channel one-cycle enable pulse, registered.
- level  out  NUM_CH  per-channel square wave, toggles on each tick, registered.

Behaviour:
- Per channel: divisor register div[i], counter cnt[i], tick[i], level[i].
- Reset (RESET=0, async):
  - div[i]=DIVS slice, cnt[i]=0, tick=0, level=0.
  - Outputs stay 0 until the first terminal count after RESET rises.
- Count, with hold=0 and div[i]>=1:
  - Each posedge: if cnt[i]==div[i]-1, then cnt[i]<=0, tick[i]<=1, level[i]<=~level[i]. Otherwise cnt[i]<=cnt[i]+1, tick[i]<=0.
  - Tick period is exactly div[i] cycles; level period is 2*div[i] cycles.
  - The first tick is high in the cycle following the div[i]-th active edge after reset, sync or write.
- div[i]==1: tick[i] is high every cycle; level[i] toggles every cycle.
- div[i]==0: channel disabled; cnt held at 0, tick 0, level holds its value.
- hold=1: cnt frozen, tick forced 0, level holds. Counting resumes from the frozen cnt, so no phase is lost.
- sync=1: all cnt<=0, tick<=0, level<=0; div unchanged. Overrides hold and div_wr counting effects.
- div_wr=1 with div_sel<NUM_CH: div[sel]<=div_data, cnt[sel]<=0, tick[sel]<=0, level[sel]<=0. Other channels are unaffected.
- div_wr with div_sel>=NUM_CH: ignored.
- Priority per channel: RESET > sync > div_wr(sel) > hold > count. div_wr in the same cycle as sync still updates div[sel].
- Counter arithmetic is unsigned CNT_W bits. Terminal compare uses div-1, evaluated only when div!=0, so there is no wrap-around.
- Outputs are registered; the single clock domain has no combinational path from inputs to outputs.

Optional Feature:
- Macro: CLKDIV_RUNTIME_EN.
- Defined: div_wr/div_sel/div_data are functional as described above.
- Undefined:
  - div[i] is the constant DIVS slice with no divisor registers.
  - div_wr, div_sel and div_data are ignored; ports remain for pin compatibility.
  - sync and hold behave unchanged.

Test Plan:
- DIVS={0,1,2,4}, RESET pulse low then high:
  - ch0 tick at cycles 4,8,12; level0 goes 1,0,1 at those ticks.
  - ch1 ticks every 2nd cycle.
  - ch2 ticks every cycle.
  - ch3 tick and level stay 0.
- Same setup, hold=1 for 3 cycles when cnt0=2: no ch0 tick during hold. The next tick arrives 2 active cycles after hold drops; the period is otherwise unchanged.
- Same setup, sync pulse mid-period: all ticks and levels go to 0 the next cycle. ch0 next ticks 4 cycles later; all channels are aligned again.
- With CLKDIV_RUNTIME_EN, div_wr sel=0 data=3 mid-count: ch0 cnt and level clear. Ticks then follow every 3 cycles; ch1/ch2 phase is undisturbed.
- div_wr sel=5 (NUM_CH=4) data=7: no register changes; all tick patterns are identical to the unwritten case.
- Without CLKDIV_RUNTIME_EN, div_wr sel=0 data=3: ch0 keeps a 4-cycle tick period.
- RESET asserted asynchronously between edges mid-count: tick and level drop to 0 immediately. After release, the first ch0 tick lands 4 cycles later.
